// File: rtl/stopwatch_mode_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: state encoding and small helpers.
// The datapath and LED logic use the same state codes.
package stopwatch_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAPV  = 2'd3
    } sw_state_e;

    function automatic logic [3:0] lap_sat_inc(input logic [3:0] value, input logic [3:0] limit);
        logic [3:0] result;
        if (value >= limit) begin
            result = value;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sw_hold_timer.sv
// Long-press timer for the lap button: counts msec ticks while enabled and
// flags expiry on the tick that completes HOLD_MS ticks.
module sw_hold_timer #(
    parameter int HOLD_MS = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic tick,
    output logic expire
);

    localparam int CW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_MS - 1);

    logic [CW-1:0] cnt_r;

    assign expire = enable && tick && (cnt_r == LAST);

    // Hold count; any release or leaving PAUSE restarts the measurement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (!enable) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= expire ? '0 : cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch mode FSM: gates the msec tick, issues lap-capture and clear strobes,
// selects frozen lap display and tracks the number of laps taken.
module stopwatch_mode_ctrl
    import stopwatch_mode_ctrl_pkg::*;
#(
    parameter int HOLD_MS  = 1000,
    parameter int MAX_LAPS = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_pulse,
    input  logic       lap_pulse,
    input  logic       lap_level,
    input  logic       tick_msec,
    output logic       tick_gated,
    output logic       lap_capture,
    output logic       clear_cnt,
    output logic       disp_lap,
    output logic [3:0] lap_idx,
    output logic [1:0] state_o
);

    localparam logic [3:0] LAP_LIMIT = 4'(MAX_LAPS);

    sw_state_e  state_r;
    sw_state_e  state_nx_s;
    logic       capture_s;
    logic       clear_s;
    logic [3:0] lap_idx_nx_s;
    logic       hold_en_s;
    logic       expire_s;

    assign hold_en_s = (state_r == ST_PAUSE) && lap_level;

    sw_hold_timer #(
        .HOLD_MS(HOLD_MS)
    ) u_hold (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (hold_en_s),
        .tick   (tick_msec),
        .expire (expire_s)
    );

    // Next-state decode; start always takes priority over lap and hold expiry.
    always_comb begin
        state_nx_s   = state_r;
        capture_s    = 1'b0;
        clear_s      = 1'b0;
        lap_idx_nx_s = lap_idx;
        case (state_r)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_pulse) begin
                    state_nx_s = ST_PAUSE;
                end else if (lap_pulse) begin
                    state_nx_s   = ST_LAPV;
                    capture_s    = 1'b1;
                    lap_idx_nx_s = lap_sat_inc(lap_idx, LAP_LIMIT);
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_LAPV: begin
                if (start_pulse) begin
                    state_nx_s = ST_PAUSE;
                end else if (lap_pulse) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_LAPV;
                end
            end
            ST_PAUSE: begin
                if (start_pulse) begin
                    state_nx_s = ST_RUN;
                end else if (expire_s) begin
                    state_nx_s   = ST_IDLE;
                    clear_s      = 1'b1;
                    lap_idx_nx_s = 4'd0;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                lap_idx_nx_s = 4'd0;
            end
        endcase
    end

    // State, lap count and registered outputs; the tick gate samples the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            lap_idx     <= 4'd0;
            tick_gated  <= 1'b0;
            lap_capture <= 1'b0;
            clear_cnt   <= 1'b0;
            disp_lap    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            lap_idx     <= lap_idx_nx_s;
            tick_gated  <= tick_msec && ((state_r == ST_RUN) || (state_r == ST_LAPV));
            lap_capture <= capture_s;
            clear_cnt   <= clear_s;
            disp_lap    <= (state_nx_s == ST_LAPV);
        end
    end

    assign state_o = state_r;

endmodule
